enemy_hit_tracker: RTL and testbench

//  Downstream consumer of the enemy formation mover. Takes the formation anchor (form_x/form_y)
//  and the player bullet position, keeps the alive bitmap of the COLS x ROWS enemy grid, and

---
 rtl/enemy_hit_tracker_if.sv | 42 ++++
 rtl/enemy_hit_tracker.sv | 165 ++++++++++++++++
 tb/tb_enemy_hit_tracker.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_hit_tracker_if.sv
// Signal bundle between the enemy hit tracker and the game-side logic
// (formation mover, bullet, renderer, game controller).
interface enemy_hit_tracker_if #(
  parameter int COLS = 8,
  parameter int ROWS = 3
);
  localparam int N     = COLS * ROWS;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic [9:0]       form_x;
  logic [9:0]       form_y;
  logic             endgame;
  logic             check_req;
  logic             bullet_active;
  logic [9:0]       bullet_x;
  logic [9:0]       bullet_y;
  logic             wave_restart;
  logic [N-1:0]     alive;
  logic             busy;
  logic             hit;
  logic             bullet_kill;
  logic [COL_W-1:0] hit_col;
  logic [ROW_W-1:0] hit_row;
  logic             done;
  logic [15:0]      score;
  logic             wave_clear;

  modport master (
    output form_x, form_y, endgame, check_req, bullet_active,
           bullet_x, bullet_y, wave_restart,
    input  alive, busy, hit, bullet_kill, hit_col, hit_row, done,
           score, wave_clear
  );

  modport slave (
    input  form_x, form_y, endgame, check_req, bullet_active,
           bullet_x, bullet_y, wave_restart,
    output alive, busy, hit, bullet_kill, hit_col, hit_row, done,
           score, wave_clear
  );
endinterface

// File: rtl/enemy_hit_tracker.sv
// Keeps the enemy alive bitmap and, per check request, scans the grid one cell
// per clock, killing the first live enemy overlapping the bullet.
module enemy_hit_tracker #(
  parameter int COLS      = 8,
  parameter int ROWS      = 3,
  parameter int CELL_W    = 24,
  parameter int CELL_H    = 24,
  parameter int ENEMY_W   = 16,
  parameter int ENEMY_H   = 12,
  parameter int BULLET_W  = 2,
  parameter int BULLET_H  = 8,
  parameter int SCORE_INC = 10
) (
  input  logic             clk,
  input  logic             reset,
  enemy_hit_tracker_if.slave bus
);
  localparam int N     = COLS * ROWS;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           r_state;
  logic             r_busy;
  logic [IDX_W-1:0] r_idx;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [9:0]       r_bx;
  logic [9:0]       r_by;
  logic [9:0]       r_fx;
  logic [10:0]      r_x0;
  logic [10:0]      r_y0;
  logic [N-1:0]     r_alive;
  logic [15:0]      r_score;
  logic             r_hit;
  logic             r_bullet_kill;
  logic [COL_W-1:0] r_hit_col;
  logic [ROW_W-1:0] r_hit_row;
  logic             r_done;
  logic             r_wave_clear;

  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic        w_overlap;
  logic        w_start;
  logic        w_kill;
  logic        w_last;
  logic [16:0] w_score_sum;
  logic [15:0] w_score_next;

  // Cell origin (r_x0/r_y0) is stepped incrementally; widened to 11 bits so nothing wraps.
  assign w_bx = {1'b0, r_bx};
  assign w_by = {1'b0, r_by};
  assign w_overlap = (w_bx < (r_x0 + 11'(ENEMY_W))) &&
                     ((w_bx + 11'(BULLET_W)) > r_x0) &&
                     (w_by < (r_y0 + 11'(ENEMY_H))) &&
                     ((w_by + 11'(BULLET_H)) > r_y0);

  assign w_start = bus.check_req & bus.bullet_active & ~bus.endgame & ~r_wave_clear;
  assign w_kill  = r_alive[r_idx] & w_overlap;
  assign w_last  = (r_idx == IDX_W'(N - 1));

  assign w_score_sum  = {1'b0, r_score} + 17'(SCORE_INC);
  assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

  // Control FSM, alive bitmap, score and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_idx         <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_bx          <= 10'd0;
      r_by          <= 10'd0;
      r_fx          <= 10'd0;
      r_x0          <= 11'd0;
      r_y0          <= 11'd0;
      r_alive       <= '1;
      r_score       <= 16'd0;
      r_hit         <= 1'b0;
      r_bullet_kill <= 1'b0;
      r_hit_col     <= '0;
      r_hit_row     <= '0;
      r_done        <= 1'b0;
      r_wave_clear  <= 1'b0;
    end else begin
      r_hit         <= 1'b0;
      r_bullet_kill <= 1'b0;
      r_done        <= 1'b0;
      r_wave_clear  <= (r_alive == '0);
      // A wave restart beats any kill and aborts a scan silently.
      if (bus.wave_restart) begin
        r_alive      <= '1;
        r_wave_clear <= 1'b0;
        r_state      <= S_IDLE;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_bx    <= bus.bullet_x;
              r_by    <= bus.bullet_y;
              r_fx    <= bus.form_x;
              r_x0    <= {1'b0, bus.form_x};
              r_y0    <= {1'b0, bus.form_y};
              r_idx   <= '0;
              r_col   <= '0;
              r_row   <= '0;
              r_state <= S_SCAN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_SCAN: begin
            if (w_kill) begin
              r_alive[r_idx] <= 1'b0;
              r_hit          <= 1'b1;
              r_bullet_kill  <= 1'b1;
              r_hit_col      <= r_col;
              r_hit_row      <= r_row;
              r_score        <= w_score_next;
              r_state        <= S_DONE;
            end else if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              if (r_col == COL_W'(COLS - 1)) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
                r_x0  <= {1'b0, r_fx};
                r_y0  <= r_y0 + 11'(CELL_H);
              end else begin
                r_col <= r_col + COL_W'(1);
                r_x0  <= r_x0 + 11'(CELL_W);
              end
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.alive       = r_alive;
  assign bus.busy        = r_busy;
  assign bus.hit         = r_hit;
  assign bus.bullet_kill = r_bullet_kill;
  assign bus.hit_col     = r_hit_col;
  assign bus.hit_row     = r_hit_row;
  assign bus.done        = r_done;
  assign bus.score       = r_score;
  assign bus.wave_clear  = r_wave_clear;
endmodule

// File: tb/tb_enemy_hit_tracker.sv
// Randomized self-checking bench for enemy_hit_tracker against a grid-level
// model (alive array, score, geometric overlap per cell).
module tb_enemy_hit_tracker;
  localparam int COLS = 8;
  localparam int ROWS = 3;
  localparam int N    = COLS * ROWS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  enemy_hit_tracker_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  enemy_hit_tracker #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;
  bit m_alive[N];
  int m_score;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v = 32'd0;
    for (int k = 0; k < N; k++) v[k] = m_alive[k];
    return v;
  endfunction

  function automatic bit model_any();
    for (int k = 0; k < N; k++) if (m_alive[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_revive();
    for (int k = 0; k < N; k++) m_alive[k] = 1'b1;
  endfunction

  // First live cell whose 16x12 box overlaps the 2x8 bullet, or -1.
  function automatic int model_find(input int bx, input int by, input int fx, input int fy);
    for (int k = 0; k < N; k++) begin
      int x0 = fx + (k % COLS) * 24;
      int y0 = fy + (k / COLS) * 24;
      if (m_alive[k] && bx < x0 + 16 && bx + 2 > x0 && by < y0 + 12 && by + 8 > y0)
        return k;
    end
    return -1;
  endfunction

  task automatic run_check(input int bx, input int by);
    bit accept;
    int exp_k, hit_n, done_n, hit_cnt, hcol, hrow, bk;
    @(negedge clk);
    bus.bullet_x  = 10'(bx);
    bus.bullet_y  = 10'(by);
    bus.check_req = 1'b1;
    accept = bus.bullet_active && !bus.endgame && model_any();
    exp_k  = accept ? model_find(bx, by, int'(bus.form_x), int'(bus.form_y)) : -1;
    @(posedge clk); #1;
    bus.check_req = 1'b0;
    check_eq("busy_after_req", {31'd0, bus.busy}, {31'd0, accept});
    hit_n = -1; done_n = -1; hit_cnt = 0; hcol = 0; hrow = 0; bk = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (bus.hit) begin
        hit_cnt++;
        if (hit_n < 0) begin
          hit_n = n; hcol = int'(bus.hit_col); hrow = int'(bus.hit_row); bk = int'(bus.bullet_kill);
        end
      end
      if (bus.done) begin
        done_n = n;
        break;
      end
    end
    if (!accept) begin
      check_eq("ignored_hit", hit_n, -1);
      check_eq("ignored_done", done_n, -1);
    end else if (exp_k >= 0) begin
      m_alive[exp_k] = 1'b0;
      m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
      check_eq("hit_cycle", hit_n, exp_k + 1);
      check_eq("hit_count", hit_cnt, 1);
      check_eq("bullet_kill", bk, 1);
      check_eq("hit_col", hcol, exp_k % COLS);
      check_eq("hit_row", hrow, exp_k / COLS);
      check_eq("done_cycle_hit", done_n, exp_k + 2);
    end else begin
      check_eq("miss_hit", hit_n, -1);
      check_eq("done_cycle_miss", done_n, N + 1);
    end
    check_eq("alive", {8'd0, bus.alive}, model_vec());
    check_eq("score", {16'd0, bus.score}, m_score);
    check_eq("wave_clear", {31'd0, bus.wave_clear}, {31'd0, !model_any()});
  endtask

  task automatic wave_restart_pulse();
    @(negedge clk);
    bus.wave_restart = 1'b1;
    @(posedge clk); #1;
    bus.wave_restart = 1'b0;
    model_revive();
    check_eq("restart_alive", {8'd0, bus.alive}, model_vec());
    check_eq("restart_wave_clear", {31'd0, bus.wave_clear}, 32'd0);
    check_eq("restart_score", {16'd0, bus.score}, m_score);
    check_eq("restart_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_revive();
    m_score = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_miss_scan();
    @(negedge clk);
    bus.bullet_x  = 10'd0;
    bus.bullet_y  = 10'd900;
    bus.check_req = 1'b1;
    @(posedge clk); #1;
    bus.check_req = 1'b0;
  endtask

  initial begin
    int xs[4];
    int done_cnt, hit_cnt, done_n;
    reset = 1'b0;
    bus.form_x = 10'd216; bus.form_y = 10'd0;
    bus.endgame = 1'b0; bus.check_req = 1'b0; bus.bullet_active = 1'b1;
    bus.bullet_x = 10'd0; bus.bullet_y = 10'd0; bus.wave_restart = 1'b0;
    model_revive();
    m_score = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_alive", {8'd0, bus.alive}, 32'h00FF_FFFF);
    check_eq("rst_score", {16'd0, bus.score}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_hit_pos", {27'd0, bus.hit_row, bus.hit_col}, 32'd0);
    check_eq("rst_pulses", {29'd0, bus.hit, bus.done, bus.wave_clear}, 32'd0);

    run_check(220, 4);
    run_check(220, 4);
    run_check(290, 28);
    check_eq("score_after_two", {16'd0, bus.score}, 32'd20);

    xs = '{214, 215, 231, 232};
    foreach (xs[i]) begin
      wave_restart_pulse();
      run_check(xs[i], 4);
    end

    bus.endgame = 1'b1;
    run_check(220, 4);
    bus.endgame = 1'b0;
    bus.bullet_active = 1'b0;
    run_check(220, 4);
    bus.bullet_active = 1'b1;

    // A second request mid-scan must be neither taken nor queued.
    wave_restart_pulse();
    start_miss_scan();
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.bullet_x = 10'd220; bus.bullet_y = 10'd4; bus.check_req = 1'b1;
    @(posedge clk); #1;
    bus.check_req = 1'b0;
    done_cnt = 0; hit_cnt = 0; done_n = -1;
    for (int n = 4; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus.hit) hit_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
    end
    check_eq("midscan_done_cycle", done_n, N + 1);
    check_eq("midscan_done_count", done_cnt, 1);
    check_eq("midscan_hits", hit_cnt, 0);
    check_eq("midscan_alive", {8'd0, bus.alive}, model_vec());

    run_check(220, 4);
    start_miss_scan();
    repeat (5) @(posedge clk);
    wave_restart_pulse();
    done_cnt = 0; hit_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (bus.hit) hit_cnt++;
      if (bus.done) done_cnt++;
    end
    check_eq("abort_done", done_cnt, 0);
    check_eq("abort_hit", hit_cnt, 0);

    run_check(220, 4);
    start_miss_scan();
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    model_revive();
    m_score = 0;
    check_eq("async_rst_alive", {8'd0, bus.alive}, 32'h00FF_FFFF);
    check_eq("async_rst_score", {16'd0, bus.score}, 32'd0);
    check_eq("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < N; k++)
      run_check(216 + (k % COLS) * 24 + 4, (k / COLS) * 24 + 4);
    check_eq("all_killed_score", {16'd0, bus.score}, 32'd240);
    check_eq("all_killed_clear", {31'd0, bus.wave_clear}, 32'd1);
    run_check(220, 4);
    wave_restart_pulse();
    check_eq("restart_keeps_score", {16'd0, bus.score}, 32'd240);

    apply_reset();
    for (int it = 0; it < 40; it++) begin
      int fx, fy, col, row;
      @(negedge clk);
      fx = int'($urandom_range(20, 700));
      fy = int'($urandom_range(20, 400));
      col = int'($urandom_range(0, COLS - 1));
      row = int'($urandom_range(0, ROWS - 1));
      bus.form_x  = 10'(fx);
      bus.form_y  = 10'(fy);
      bus.endgame = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) wave_restart_pulse();
      run_check(fx + col * 24 + int'($urandom_range(0, 34)) - 10,
                fy + row * 24 + int'($urandom_range(0, 30)) - 10);
    end
    bus.endgame = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
